// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   Issue controller for the decode stage. Keeps a small pending-write counter
//   per architectural register and a count of instructions in flight. Holds
//   the instruction at decode until its sources are clean. Serialises CSR/ecall
//   instructions by draining the pipeline before issue and holding off further
//   issue until the CSR itself has retired.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   id_*           decoded instruction at decode (valid, sources, dest, CSR flag)
//   ex_ready       execute stage can accept an instruction this cycle
//   flush          redirect; kills the instruction at decode this cycle
//   wb_we/wb_addr  register write at writeback (clears one pending write)
//   wb_retire      one instruction of any type leaves writeback
//   issue          instruction at decode moves to execute this cycle
//   id_stall       decode/fetch must hold
//   busy_mask      bit i set when register i has a pending write (bit 0 is 0)
//   csr_state      serialisation FSM state, for debug
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int CNT_W = 2,
    parameter int OUT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    input  logic        id_is_csr,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic        wb_retire,
    output logic        issue,
    output logic        id_stall,
    output logic [31:0] busy_mask,
    output logic [1:0]  csr_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        CSR_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [OUT_W-1:0] inflight_q, inflight_d;
    state_e           state_q, state_d;

    logic        hazard;
    logic        fsm_allow;
    logic        issue_w;
    logic        infl_zero, infl_full;
    logic [31:0] inc_vec, dec_vec;
    logic [31:0] busy_w;

    assign infl_zero = (inflight_q == '0);
    assign infl_full = (inflight_q == OUT_MAX);

    // No forwarding: any pending write to a source stalls. A destination whose
    // counter is already saturated also stalls, since one more would overflow.
    assign hazard = (id_rs1_used && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0))
                 || (id_rs2_used && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0))
                 || (id_rd_wen   && (id_rd  != 5'd0) && (cnt_q[id_rd]  == CNT_MAX));

    // Allow decision uses only the registered in-flight count; a retire in the
    // same cycle does not open the gate until the following cycle.
    always_comb begin
        fsm_allow = 1'b0;
        unique case (state_q)
            IDLE:     fsm_allow = id_is_csr ? infl_zero : 1'b1;
            DRAIN:    fsm_allow = infl_zero;
            CSR_WAIT: fsm_allow = 1'b0;
            default:  fsm_allow = 1'b0;
        endcase
        if (infl_full) begin
            fsm_allow = 1'b0;
        end
    end

    assign issue_w  = id_valid && ex_ready && !flush && !hazard && fsm_allow && !rst;
    assign issue    = issue_w;
    assign id_stall = rst || (id_valid && !flush && !issue_w);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (id_valid && id_is_csr && !flush) begin
                    if (issue_w) begin
                        state_d = CSR_WAIT;
                    end else if (!infl_zero) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (issue_w) begin
                    state_d = CSR_WAIT;
                end else if (flush || !id_valid) begin
                    state_d = IDLE;
                end
            end
            CSR_WAIT: begin
                // flush does not matter here: the CSR has already left decode.
                if (infl_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-hot increment/decrement requests; bit 0 is ignored so x0 never counts.
    assign inc_vec = (issue_w && id_rd_wen) ? (32'd1 << id_rd)   : 32'd0;
    assign dec_vec = wb_we                  ? (32'd1 << wb_addr) : 32'd0;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        cnt_d[0] = '0;
        for (int i = 1; i < 32; i++) begin
            if (inc_vec[i] && !dec_vec[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
                // A decrement at zero is a protocol error; hold at zero.
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue_w && !wb_retire && !infl_full) begin
            inflight_d = inflight_q + 1'b1;
        end else if (wb_retire && !issue_w && !infl_zero) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= '0;
            state_q    <= IDLE;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        busy_w = 32'd0;
        for (int i = 1; i < 32; i++) begin
            busy_w[i] = (cnt_q[i] != '0);
        end
    end

    assign busy_mask = rst ? 32'd0 : busy_w;
    assign csr_state = rst ? IDLE  : state_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//   Directed bench for issue_scoreboard. The driver sets decode/writeback inputs
//   shortly after each rising edge and queues the hand-computed expected outputs
//   for that cycle; a monitor samples the DUT on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_wen, id_is_csr;
    logic        ex_ready, flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic        wb_retire;
    logic        issue, id_stall;
    logic [31:0] busy_mask;
    logic [1:0]  csr_state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic        iss;
        logic        stl;
        logic [31:0] bm;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    issue_scoreboard #(.CNT_W(2), .OUT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_wen   (id_rd_wen),
        .id_is_csr   (id_is_csr),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_retire   (wb_retire),
        .issue       (issue),
        .id_stall    (id_stall),
        .busy_mask   (busy_mask),
        .csr_state   (csr_state)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got=%h expected=%h at %0t", nm, fld, got, exp, $time);
        end
    endtask

    // Monitor: one queued expectation per cycle, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "issue",     {31'd0, issue},     {31'd0, e.iss});
            chk(e.nm, "id_stall",  {31'd0, id_stall},  {31'd0, e.stl});
            chk(e.nm, "busy_mask", busy_mask,          e.bm);
            chk(e.nm, "csr_state", {30'd0, csr_state}, {30'd0, e.st});
        end
    end

    // Set decode inputs; writeback/flush cleared, execute ready.
    task automatic op(input logic v, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wen, input logic csr);
        id_valid = v;   id_rs1 = r1; id_rs1_used = u1;
        id_rs2 = r2;    id_rs2_used = u2;
        id_rd = rd;     id_rd_wen = wen; id_is_csr = csr;
        ex_ready = 1'b1; flush = 1'b0;
        wb_we = 1'b0;   wb_addr = 5'd0; wb_retire = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic we, input logic ret);
        wb_we = we; wb_addr = a; wb_retire = ret;
    endtask

    task automatic cyc(input string nm, input logic iss, input logic stl,
                       input logic [31:0] bm, input logic [1:0] st);
        exp_t e;
        e.nm = nm; e.iss = iss; e.stl = stl; e.bm = bm; e.st = st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] b(input int i);
        return 32'd1 << i;
    endfunction

    initial begin
        rst = 1'b1;
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        // Reset holds outputs even with a valid instruction present
        op(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        cyc("reset", 1'b0, 1'b1, 32'd0, 2'd0);
        rst = 1'b0;

        // RAW hazard on x5, cleared by writeback
        op(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);  cyc("raw_addi", 1, 0, 32'd0, 0);
        op(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);  cyc("raw_stall", 0, 1, b(5), 0);
        op(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        wb(5'd5, 1, 1);                                       cyc("raw_wb", 0, 1, b(5), 0);
        op(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);  cyc("raw_issue", 1, 0, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd6, 1, 1);                                       cyc("raw_ret6", 0, 0, b(6), 0);

        // x0 never tracked
        op(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);  cyc("x0_a", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);  cyc("x0_b", 1, 0, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd0, 1, 1);                                       cyc("x0_ret1", 0, 0, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd0, 0, 1);                                       cyc("x0_ret2", 0, 0, 32'd0, 0);

        // Same-cycle increment and decrement on x7
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);  cyc("x7_first", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        wb(5'd7, 1, 1);                                       cyc("x7_both", 1, 0, b(7), 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("x7_held", 0, 0, b(7), 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd7, 1, 1);                                       cyc("x7_ret", 0, 0, b(7), 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("x7_clear", 0, 0, 32'd0, 0);

        // Pending counter saturation on x9
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  cyc("x9_w1", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  cyc("x9_w2", 1, 0, b(9), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  cyc("x9_w3", 1, 0, b(9), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  cyc("x9_w4_stall", 0, 1, b(9), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        wb(5'd9, 1, 1);                                       cyc("x9_w4_wb", 0, 1, b(9), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  cyc("x9_w4_issue", 1, 0, b(9), 0);
        for (int k = 0; k < 3; k++) begin
            op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            wb(5'd9, 1, 1);                                   cyc("x9_drain", 0, 0, b(9), 0);
        end
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("x9_clear", 0, 0, 32'd0, 0);

        // CSR serialisation with two in flight
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); cyc("csr_pre10", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0); cyc("csr_pre11", 1, 0, b(10), 0);
        op(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1); cyc("csr_idle_hold", 0, 1, b(10) | b(11), 0);
        op(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        wb(5'd10, 1, 1);                                      cyc("csr_drain1", 0, 1, b(10) | b(11), 1);
        op(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        wb(5'd11, 1, 1);                                      cyc("csr_drain2", 0, 1, b(11), 1);
        op(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1); cyc("csr_issue", 1, 0, 32'd0, 1);
        op(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); cyc("csr_wait1", 0, 1, b(12), 2);
        op(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        wb(5'd12, 1, 1);                                      cyc("csr_wait_ret", 0, 1, b(12), 2);
        op(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); cyc("csr_wait_exit", 0, 1, 32'd0, 2);
        op(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); cyc("csr_next_issue", 1, 0, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd13, 1, 1);                                      cyc("csr_ret13", 0, 0, b(13), 0);

        // Flush while stalled on a hazard
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0); cyc("fl_pre14", 1, 0, 32'd0, 0);
        op(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        flush = 1'b1;                                         cyc("fl_flush", 0, 0, b(14), 0);
        op(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0); cyc("fl_after", 0, 1, b(14), 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd14, 1, 1);                                      cyc("fl_ret14", 0, 0, b(14), 0);

        // Reset in the middle of DRAIN
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0); cyc("rd_pre16", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);  cyc("rd_csr_hold", 0, 1, b(16), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        rst = 1'b1;                                           cyc("rd_rst", 0, 1, 32'd0, 0);
        rst = 1'b0;
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("rd_after", 0, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);  cyc("rd_csr_now", 1, 0, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd0, 0, 1);                                       cyc("rd_csr_ret", 0, 0, 32'd0, 2);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("rd_wait_exit", 0, 0, 32'd0, 2);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("rd_idle", 0, 0, 32'd0, 0);

        // Flush during DRAIN returns to IDLE
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0); cyc("df_pre17", 1, 0, 32'd0, 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);  cyc("df_csr_hold", 0, 1, b(17), 0);
        op(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        flush = 1'b1;                                         cyc("df_flush", 0, 0, b(17), 1);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb(5'd17, 1, 1);                                      cyc("df_ret17", 0, 0, b(17), 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("df_clear", 0, 0, 32'd0, 0);

        // Execute not ready
        op(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        ex_ready = 1'b0;                                      cyc("exr_low", 0, 1, 32'd0, 0);
        op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);  cyc("exr_idle", 0, 0, 32'd0, 0);

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue left=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
